// File: rtl/free_ptr_mgr.sv
// free_ptr_mgr
//   Free-pointer manager for the shared packet buffer. After reset it waits
//   INIT_DLY cycles and then fills its free list with every pointer
//   0..NUM_PTR-1, one per cycle. In ACTIVE it hands out the head pointer on
//   allocation and takes pointers back on release. A per-pointer in-use
//   bitmap rejects double-frees and out-of-range releases.
//
// Ports
//   clk, rstn   clock, asynchronous active-low reset
//   alloc_req   pop the head pointer (honoured only while alloc_vld=1)
//   alloc_vld   alloc_ptr holds a valid free pointer (show-ahead)
//   alloc_ptr   head of the free list
//   rls_vld     release request, one pointer per cycle
//   rls_ptr     pointer being released
//   free_cnt    number of free pointers held
//   low_wm      registered: free_cnt <= LOW_WM while ACTIVE
//   init_done   high from ACTIVE entry until the next reset
//   rls_err     one-cycle pulse: a release was rejected
//   alloc_err   one-cycle pulse: alloc_req seen while alloc_vld=0

module free_ptr_mgr #(
  parameter int PTR_W    = 10,
  parameter int NUM_PTR  = 512,
  parameter int INIT_DLY = 4,
  parameter int LOW_WM   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_req,
  output logic             alloc_vld,
  output logic [PTR_W-1:0] alloc_ptr,
  input  logic             rls_vld,
  input  logic [PTR_W-1:0] rls_ptr,
  output logic [PTR_W:0]   free_cnt,
  output logic             low_wm,
  output logic             init_done,
  output logic             rls_err,
  output logic             alloc_err
);

  localparam int IDX_W = (NUM_PTR > 1) ? $clog2(NUM_PTR) : 1;
  localparam int DLY_W = $clog2(INIT_DLY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PTR - 1);
  localparam logic [DLY_W-1:0] DLY_LAST    = DLY_W'(INIT_DLY - 1);
  localparam logic [PTR_W:0]   LOW_WM_CNT  = (PTR_W + 1)'(LOW_WM);

  typedef enum logic [1:0] {ST_WAIT, ST_FILL, ST_ACTIVE} state_t;

  state_t state_reg, state_next;

  logic                fill_en;
  logic                active;
  logic [DLY_W-1:0]    dly_cnt_reg;
  logic [IDX_W-1:0]    rd_idx_reg, wr_idx_reg;
  logic [IDX_W-1:0]    rd_idx_next, wr_idx_inc;
  logic [PTR_W:0]      cnt_next, cnt_after_pop;
  logic                pop, push, rls_ok;
  logic [PTR_W-1:0]    push_ptr;
  logic [NUM_PTR-1:0]  bitmap_reg, bitmap_next;
  // Bitmap widened to the full pointer space; pointers >= NUM_PTR read as
  // "free", so an out-of-range release fails the same test as a double-free.
  logic [2**PTR_W-1:0] bitmap_ext;

  // Free-list storage; no reset so it maps onto block RAM.
  logic [PTR_W-1:0] mem [NUM_PTR];

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_WAIT;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT:   if (dly_cnt_reg == DLY_LAST) state_next = ST_FILL;
      ST_FILL:   if (wr_idx_reg == LAST_IDX)  state_next = ST_ACTIVE;
      ST_ACTIVE: state_next = ST_ACTIVE;
      default:   state_next = ST_WAIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fill_en   = (state_reg == ST_FILL);
    active    = (state_reg == ST_ACTIVE);
    init_done = active;
  end

  // Idle-delay counter; saturates once the last WAIT cycle is reached.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dly_cnt_reg <= '0;
    else if (state_reg == ST_WAIT && dly_cnt_reg != DLY_LAST)
      dly_cnt_reg <= dly_cnt_reg + DLY_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2**PTR_W; gi++) begin : g_ext
      if (gi < NUM_PTR) begin : g_in
        assign bitmap_ext[gi] = bitmap_reg[gi];
      end else begin : g_out
        assign bitmap_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------- Datapath control ----------------
  // alloc_vld is only ever set in ACTIVE, so pop is implicitly ACTIVE-only.
  // The bitmap lookup uses the pre-cycle state: a pointer allocated this
  // cycle is still marked free and its release is rejected.
  always_comb begin
    pop           = alloc_req & alloc_vld;
    rls_ok        = active & rls_vld & bitmap_ext[rls_ptr];
    push          = fill_en | rls_ok;
    push_ptr      = fill_en ? PTR_W'(wr_idx_reg) : rls_ptr;
    rd_idx_next   = pop ? wrap_inc(rd_idx_reg) : rd_idx_reg;
    wr_idx_inc    = wrap_inc(wr_idx_reg);
    cnt_after_pop = free_cnt - (PTR_W + 1)'(pop);
    cnt_next      = cnt_after_pop + (PTR_W + 1)'(push);
  end

  generate
    for (gi = 0; gi < NUM_PTR; gi++) begin : g_bit
      assign bitmap_next[gi] =
          (fill_en && wr_idx_reg == IDX_W'(gi)) ? 1'b0 :
          (pop     && alloc_ptr  == PTR_W'(gi)) ? 1'b1 :
          (rls_ok  && rls_ptr    == PTR_W'(gi)) ? 1'b0 :
                                                  bitmap_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bitmap_reg <= '1;
    else       bitmap_reg <= bitmap_next;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx_reg] <= push_ptr;
  end

  // The head register reads the entry at the post-pop read index. A push
  // landing on that same entry this cycle is not yet visible (read-first),
  // so alloc_vld only counts entries that were stored before this cycle.
  // That gives the one-cycle pop turnaround and the two-cycle
  // empty-to-valid latency after a release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_idx_reg <= '0;
      wr_idx_reg <= '0;
      free_cnt   <= '0;
      alloc_vld  <= 1'b0;
      alloc_ptr  <= '0;
      low_wm     <= 1'b0;
      rls_err    <= 1'b0;
      alloc_err  <= 1'b0;
    end else begin
      if (push) wr_idx_reg <= wr_idx_inc;
      rd_idx_reg <= rd_idx_next;
      free_cnt   <= cnt_next;
      alloc_vld  <= active && (cnt_after_pop != '0);
      if (active) alloc_ptr <= mem[rd_idx_next];
      // Evaluated on next-cycle values so low_wm lines up with free_cnt.
      low_wm     <= (state_next == ST_ACTIVE) && (cnt_next <= LOW_WM_CNT);
      rls_err    <= rls_vld & ~rls_ok;
      alloc_err  <= alloc_req & ~alloc_vld;
    end
  end

endmodule

// File: tb/tb_free_ptr_mgr.sv
// tb_free_ptr_mgr
//   Self-checking bench for free_ptr_mgr. A queue-based reference model holds
//   the free pointers in FIFO order together with the cycle each one was
//   returned; a pointer becomes visible at the head two cycles after its
//   release. Directed phases walk through init, allocation, double-free,
//   out-of-range release, drain/refill and the low watermark, followed by a
//   randomized phase and a reset in the middle of the fill.

module tb_free_ptr_mgr;

  localparam int PTR_W    = 10;
  localparam int NUM_PTR  = 512;
  localparam int INIT_DLY = 4;
  localparam int LOW_WM   = 16;

  logic             clk;
  logic             rstn;
  logic             alloc_req;
  logic             alloc_vld;
  logic [PTR_W-1:0] alloc_ptr;
  logic             rls_vld;
  logic [PTR_W-1:0] rls_ptr;
  logic [PTR_W:0]   free_cnt;
  logic             low_wm;
  logic             init_done;
  logic             rls_err;
  logic             alloc_err;

  free_ptr_mgr #(
    .PTR_W(PTR_W), .NUM_PTR(NUM_PTR), .INIT_DLY(INIT_DLY), .LOW_WM(LOW_WM)
  ) dut (
    .clk(clk), .rstn(rstn),
    .alloc_req(alloc_req), .alloc_vld(alloc_vld), .alloc_ptr(alloc_ptr),
    .rls_vld(rls_vld), .rls_ptr(rls_ptr),
    .free_cnt(free_cnt), .low_wm(low_wm), .init_done(init_done),
    .rls_err(rls_err), .alloc_err(alloc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model
  int q[$];                 // free pointers, head first
  int pc[$];                // cycle each queued pointer became free
  bit alloc_map [NUM_PTR];  // 1 = pointer is out with a user
  int cyc;
  bit exp_aerr;
  bit exp_rerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rstn      = 1'b0;
    alloc_req = 1'b0;
    rls_vld   = 1'b0;
    rls_ptr   = '0;
    #1;
    chk("rst_free_cnt",  free_cnt,  0);
    chk("rst_alloc_vld", alloc_vld, 0);
    chk("rst_alloc_ptr", alloc_ptr, 0);
    chk("rst_low_wm",    low_wm,    0);
    chk("rst_init_done", init_done, 0);
    chk("rst_rls_err",   rls_err,   0);
    chk("rst_alloc_err", alloc_err, 0);
    @(negedge clk);
    @(negedge clk);
    rstn     = 1'b1;
    exp_aerr = 1'b0;
    exp_rerr = 1'b0;
  endtask

  // Runs WAIT/FILL with random requests (all must be refused) until
  // init_done rises or max_cyc cycles pass.
  task automatic init_phase(input int max_cyc, output int n);
    bit req, rv;
    n = 0;
    while (n < max_cyc && init_done !== 1'b1) begin
      chk("init_alloc_vld", alloc_vld, 0);
      chk("init_low_wm",    low_wm,    0);
      chk("init_alloc_err", alloc_err, exp_aerr);
      chk("init_rls_err",   rls_err,   exp_rerr);
      req       = 1'($urandom_range(0, 1));
      rv        = 1'($urandom_range(0, 1));
      alloc_req = req;
      rls_vld   = rv;
      rls_ptr   = PTR_W'($urandom_range(0, NUM_PTR - 1));
      exp_aerr  = req;
      exp_rerr  = rv;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic model_init();
    q.delete();
    pc.delete();
    cyc = 0;
    for (int i = 0; i < NUM_PTR; i++) begin
      q.push_back(i);
      pc.push_back(-1);
      alloc_map[i] = 1'b0;
    end
  endtask

  // One ACTIVE cycle: check outputs against the model, drive inputs,
  // advance the model.
  task automatic step(input bit req, input bit rv, input int rp);
    bit vld, pop, acc;
    vld = (q.size() > 0) && (cyc - pc[0] >= 2);
    chk("init_done", init_done, 1);
    chk("free_cnt",  free_cnt,  q.size());
    chk("alloc_vld", alloc_vld, vld);
    if (vld) chk("alloc_ptr", alloc_ptr, q[0]);
    chk("low_wm",    low_wm,    (q.size() <= LOW_WM));
    chk("alloc_err", alloc_err, exp_aerr);
    chk("rls_err",   rls_err,   exp_rerr);
    alloc_req = req;
    rls_vld   = rv;
    rls_ptr   = rp[PTR_W-1:0];
    pop = req && vld;
    acc = 1'b0;
    if (rv && rp >= 0 && rp < NUM_PTR) acc = alloc_map[rp];
    exp_aerr = req && !vld;
    exp_rerr = rv && !acc;
    if (pop) begin
      alloc_map[q[0]] = 1'b1;
      void'(q.pop_front());
      void'(pc.pop_front());
    end
    if (acc) begin
      alloc_map[rp] = 1'b0;
      q.push_back(rp);
      pc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic int pick_alloc();
    int start;
    start = $urandom_range(0, NUM_PTR - 1);
    for (int i = 0; i < NUM_PTR; i++) begin
      if (alloc_map[(start + i) % NUM_PTR]) return (start + i) % NUM_PTR;
    end
    return 0;
  endfunction

  initial begin
    int n;
    int guard;
    rstn      = 1'b1;
    alloc_req = 1'b0;
    rls_vld   = 1'b0;
    rls_ptr   = '0;
    exp_aerr  = 1'b0;
    exp_rerr  = 1'b0;

    $display("phase: reset and init");
    apply_reset();
    init_phase(2000, n);
    chk("init_latency", (n >= INIT_DLY + NUM_PTR && n <= INIT_DLY + NUM_PTR + 1), 1);
    model_init();
    step(0, 0, 0);
    step(0, 0, 0);

    $display("phase: back-to-back allocs then release 1");
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 0, 0);

    $display("phase: double-free and out-of-range release");
    step(0, 1, 1);
    step(0, 1, 600);
    step(0, 0, 0);
    step(0, 0, 0);

    $display("phase: drain, extra alloc, refill with 7");
    guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      step(1, 0, 0);
      guard++;
    end
    chk("drain_done", q.size(), 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 7);
    repeat (3) step(0, 0, 0);

    $display("phase: simultaneous alloc/release and low watermark");
    for (int p = 100; p < 120; p++) step(0, 1, p);
    step(0, 0, 0);
    step(1, 1, 50);
    step(0, 0, 0);
    step(1, 1, q[0]);
    step(0, 0, 0);
    repeat (15) step(1, 0, 0);
    repeat (15) step(0, 1, pick_alloc());
    step(0, 0, 0);

    $display("phase: random traffic");
    repeat (3000) begin
      bit req, rv;
      int rp;
      req = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      rp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : pick_alloc();
      step(req, rv, rp);
    end

    $display("phase: reset during fill");
    apply_reset();
    init_phase(INIT_DLY + 100, n);
    chk("fill_not_done", init_done, 0);
    apply_reset();
    init_phase(2000, n);
    chk("reinit_latency", (n >= INIT_DLY + NUM_PTR && n <= INIT_DLY + NUM_PTR + 1), 1);
    model_init();
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    alloc_req = 1'b0;
    rls_vld   = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
